udp_pkt_buf: RTL and testbench

Ping-pong packet buffer between the UDP receive path and the UDP transmit path of the Ethernet loopback design. It stores the 32-bit payload words written by the IP receiver into one of two 512-word banks. On frame completion it commits the bank and latches the frame lengths. It then presents the committed bank to the IP sender via a request/ack/done handshake and a read port addressed by the sender.

---
 rtl/udp_pkg.sv | 21 ++
 rtl/udp_bank_ram.sv | 34 +++
 rtl/udp_pkt_buf.sv | 137 +++++++++++++
 tb/tb_udp_pkt_buf.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP loopback packet buffer: TX handshake states,
// header/length constants and the payload word-count helper.
package udp_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_e;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam int          MAX_UDP_LEN   = 32'd2056;

    // Payload words covered by a UDP length: header removed, rounded up to whole words.
    function automatic logic [9:0] udp_words(input logic [15:0] udp_len);
        logic [15:0] adj_s;
        adj_s = udp_len - UDP_HDR_BYTES + 16'd3;
        return adj_s[11:2];
    endfunction

endpackage

// File: rtl/udp_bank_ram.sv
// Two-bank payload store: simple dual-port RAM, one write port, one registered
// read port, address formed as {bank, word}.
module udp_bank_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Write port; contents are deliberately left uninitialised so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; only the output register is cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/udp_pkt_buf.sv
// Ping-pong packet buffer between the UDP receiver and the UDP sender: frames are
// committed into alternating banks and offered to the sender with req/ack/done.
module udp_pkt_buf #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int MAX_UDP_LEN = udp_pkg::MAX_UDP_LEN
) (
    input  logic              g_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rx_done,
    input  logic [15:0]       rx_data_length,
    input  logic [15:0]       rx_total_length,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              tx_req,
    input  logic              tx_ack,
    input  logic              tx_done,
    output logic [15:0]       tx_data_length,
    output logic [15:0]       tx_total_length,
    output logic [9:0]        tx_words,
    output logic [15:0]       drop_cnt
);

    import udp_pkg::*;

    localparam logic [15:0] MAX_LEN_C = 16'(MAX_UDP_LEN);

    tx_state_e   state_r;
    logic        wb_r;
    logic        rb_r;
    logic [1:0]  full_r;
    logic [15:0] bank_dlen_r [2];
    logic [15:0] bank_tlen_r [2];

    logic        len_ok_s;
    logic        free_s;
    logic [1:0]  full_post_s;
    logic        commit_s;
    logic        drop_s;
    logic        wr_ok_s;

    // Commit decision: a same-cycle sender release counts before the target bank is tested.
    always_comb begin
        len_ok_s    = (rx_data_length > UDP_HDR_BYTES) && (rx_data_length <= MAX_LEN_C);
        free_s      = (state_r == TX_BUSY) && tx_done;
        full_post_s = full_r;
        if (free_s) begin
            full_post_s[rb_r] = 1'b0;
        end else begin
            full_post_s = full_r;
        end
        commit_s = rx_done && len_ok_s && !full_post_s[wb_r];
        drop_s   = rx_done && !commit_s;
        wr_ok_s  = wr_en && !full_post_s[wb_r];
    end

    // Receive-side bookkeeping: bank occupancy, write-bank pointer, latched lengths, drops.
    always_ff @(posedge g_clk) begin
        if (reset) begin
            wb_r           <= 1'b0;
            full_r         <= 2'b00;
            drop_cnt       <= 16'd0;
            bank_dlen_r[0] <= 16'd0;
            bank_dlen_r[1] <= 16'd0;
            bank_tlen_r[0] <= 16'd0;
            bank_tlen_r[1] <= 16'd0;
        end else begin
            full_r <= full_post_s;
            if (commit_s) begin
                full_r[wb_r]      <= 1'b1;
                bank_dlen_r[wb_r] <= rx_data_length;
                bank_tlen_r[wb_r] <= rx_total_length;
                wb_r              <= ~wb_r;
            end
            if (drop_s && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Sender handshake FSM; lengths are captured on REQ entry and held through BUSY.
    always_ff @(posedge g_clk) begin
        if (reset) begin
            state_r         <= TX_IDLE;
            rb_r            <= 1'b0;
            tx_req          <= 1'b0;
            tx_data_length  <= 16'd0;
            tx_total_length <= 16'd0;
            tx_words        <= 10'd0;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    if (full_r[rb_r]) begin
                        state_r         <= TX_REQ;
                        tx_req          <= 1'b1;
                        tx_data_length  <= bank_dlen_r[rb_r];
                        tx_total_length <= bank_tlen_r[rb_r];
                        tx_words        <= udp_words(bank_dlen_r[rb_r]);
                    end
                end
                TX_REQ: begin
                    if (tx_ack) begin
                        state_r <= TX_BUSY;
                        tx_req  <= 1'b0;
                    end
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        rb_r    <= ~rb_r;
                        state_r <= TX_IDLE;
                    end
                end
                default: begin
                    state_r <= TX_IDLE;
                    tx_req  <= 1'b0;
                end
            endcase
        end
    end

    udp_bank_ram #(
        .AW (ADDR_W + 1),
        .DW (DATA_W)
    ) u_ram (
        .clk   (g_clk),
        .reset (reset),
        .we    (wr_ok_s),
        .waddr ({wb_r, wr_addr}),
        .wdata (wr_data),
        .raddr ({rb_r, rd_addr}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_udp_pkt_buf.sv
// Bench for udp_pkt_buf: directed and randomized frames checked against a
// frame-queue model (at most two held frames, FIFO order, saturating drop count).
module tb_udp_pkt_buf;

    logic        g_clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rx_done;
    logic [15:0] rx_data_length;
    logic [15:0] rx_total_length;
    logic [8:0]  rd_addr;
    logic [31:0] rd_data;
    logic        tx_req;
    logic        tx_ack;
    logic        tx_done;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic [9:0]  tx_words;
    logic [15:0] drop_cnt;

    udp_pkt_buf dut (
        .g_clk           (g_clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rx_done         (rx_done),
        .rx_data_length  (rx_data_length),
        .rx_total_length (rx_total_length),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .tx_req          (tx_req),
        .tx_ack          (tx_ack),
        .tx_done         (tx_done),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .tx_words        (tx_words),
        .drop_cnt        (drop_cnt)
    );

    always #5 g_clk = ~g_clk;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    // Reference model: held frames in arrival order, payloads concatenated.
    logic [15:0] q_dl[$];
    logic [15:0] q_tl[$];
    bit          q_chk[$];
    logic [31:0] q_data[$];
    logic [31:0] open_data[$];
    int          m_drop = 0;

    function automatic int nwords(input int dl);
        return (dl - 8 + 3) / 4;
    endfunction

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscmp_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic release_front();
        int n;
        if (q_dl.size() > 0) begin
            n = nwords(int'(q_dl[0]));
            for (int i = 0; i < n; i++) void'(q_data.pop_front());
            void'(q_dl.pop_front());
            void'(q_tl.pop_front());
            void'(q_chk.pop_front());
        end
    endtask

    task automatic write_frame(input int nw, input logic [31:0] base, input bit rnd);
        open_data.delete();
        for (int i = 0; i < nw; i++) begin
            wr_en   = 1'b1;
            wr_addr = 9'(i);
            wr_data = rnd ? $urandom : base + 32'(i);
            open_data.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic commit(input logic [15:0] dl, input logic [15:0] tl, input bit with_done, input bit chk);
        int d;
        d               = int'(dl);
        rx_done         = 1'b1;
        rx_data_length  = dl;
        rx_total_length = tl;
        tx_done         = with_done;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        if (with_done) release_front();
        if (d > 8 && d <= 2056 && q_dl.size() < 2) begin
            q_dl.push_back(dl);
            q_tl.push_back(tl);
            q_chk.push_back(chk);
            for (int i = 0; i < nwords(d); i++)
                q_data.push_back((i < open_data.size()) ? open_data[i] : 32'd0);
        end else if (m_drop < 65535) begin
            m_drop++;
        end
        open_data.delete();
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic start_tx();
        int n;
        n = 0;
        while (tx_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("tx_req_rise", 32'(tx_req), 32'd1);
        if (q_dl.size() > 0) begin
            check("tx_data_length", 32'(tx_data_length), 32'(q_dl[0]));
            check("tx_total_length", 32'(tx_total_length), 32'(q_tl[0]));
            check("tx_words", 32'(tx_words), 32'(nwords(int'(q_dl[0]))));
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
            check("tx_req_fall", 32'(tx_req), 32'd0);
            if (q_chk[0]) begin
                for (int i = 0; i < nwords(int'(q_dl[0])); i++) begin
                    rd_addr = 9'(i);
                    tick();
                    check("rd_data", rd_data, q_data[i]);
                end
            end
            check("len_stable", 32'(tx_data_length), 32'(q_dl[0]));
        end
    endtask

    task automatic finish_tx();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        release_front();
        check("tx_req_after_done", 32'(tx_req), 32'd0);
    endtask

    task automatic service();
        start_tx();
        finish_tx();
    endtask

    task automatic send_frame(input logic [15:0] dl, input logic [15:0] tl);
        write_frame(nwords(int'(dl)), 32'd0, 1'b1);
        commit(dl, tl, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] dl;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 9'd0; wr_data = 32'd0;
        rx_done = 1'b0; rx_data_length = 16'd0; rx_total_length = 16'd0;
        rd_addr = 9'd0; tx_ack = 1'b0; tx_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_tx_words", 32'(tx_words), 32'd0);
        check("rst_tx_data_length", 32'(tx_data_length), 32'd0);
        check("rst_tx_total_length", 32'(tx_total_length), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // Single frame with fixed payload, request latency and handshake rules.
        write_frame(3, 32'hA0, 1'b0);
        commit(16'd20, 16'd48, 1'b0, 1'b1);
        check("req_lat_n1", 32'(tx_req), 32'd0);
        tick();
        check("req_lat_n2", 32'(tx_req), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done_in_req_ignored", 32'(tx_req), 32'd1);
        repeat (3) tick();
        check("req_held", 32'(tx_req), 32'd1);
        service();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        tick();
        check("ack_in_idle_ignored", 32'(tx_req), 32'd0);

        // Ping-pong: two held frames, third dropped, then served in order.
        send_frame(16'($urandom_range(9, 120)), 16'd100);
        send_frame(16'($urandom_range(9, 120)), 16'd200);
        commit(16'd40, 16'd60, 1'b0, 1'b0);
        service();
        service();

        // Length bounds.
        commit(16'd8, 16'd28, 1'b0, 1'b0);
        commit(16'd2057, 16'd2077, 1'b0, 1'b0);
        send_frame(16'd9, 16'd29);
        service();
        send_frame(16'd2056, 16'd2076);
        service();

        // Release and commit in the same cycle with both banks held.
        send_frame(16'd30, 16'd50);
        send_frame(16'd44, 16'd64);
        start_tx();
        commit(16'd60, 16'd80, 1'b1, 1'b0);
        service();
        service();

        // Randomized frames, occasionally invalid, served at random points.
        for (int k = 0; k < 20; k++) begin
            if (q_dl.size() == 2) service();
            if ($urandom_range(0, 5) == 0) begin
                dl = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom_range(2057, 4000));
                write_frame(2, 32'd0, 1'b1);
                commit(dl, dl + 16'd20, 1'b0, 1'b1);
            end else begin
                dl = 16'($urandom_range(9, 160));
                send_frame(dl, dl + 16'd20);
            end
            if ($urandom_range(0, 2) == 0 && q_dl.size() > 0) service();
        end
        while (q_dl.size() > 0) service();

        // Reset in the middle of a transmit.
        send_frame(16'd36, 16'd56);
        start_tx();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_dl.delete(); q_tl.delete(); q_chk.delete(); q_data.delete();
        m_drop = 0;
        check("mid_rst_tx_req", 32'(tx_req), 32'd0);
        check("mid_rst_rd_data", rd_data, 32'd0);
        check("mid_rst_tx_words", 32'(tx_words), 32'd0);
        check("mid_rst_tx_data_length", 32'(tx_data_length), 32'd0);
        check("mid_rst_tx_total_length", 32'(tx_total_length), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (3) tick();
        check("no_stale_req", 32'(tx_req), 32'd0);
        send_frame(16'd28, 16'd48);
        service();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
